// File: rtl/apple1_bus_pkg.sv
// Shared types and constants for the Apple-1 bus decoder: slave select
// encoding, PIA register offsets, default memory map and the address decoder.
package apple1_bus_pkg;

    // Which slave owns the current CPU address
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ROM  = 2'd1,
        SEL_RAM  = 2'd2,
        SEL_PIA  = 2'd3
    } sel_t;

    // PIA register offsets (cpu_addr[1:0] inside the PIA window)
    localparam logic [1:0] PIA_KBD   = 2'd0;
    localparam logic [1:0] PIA_KBDCR = 2'd1;
    localparam logic [1:0] PIA_DSP   = 2'd2;
    localparam logic [1:0] PIA_DSPCR = 2'd3;

    // Default Apple-1 memory map
    localparam int          DEF_RAM_ADDR_BITS = 12;
    localparam logic [15:0] DEF_ROM_BASE      = 16'hFF00;
    localparam logic [15:0] DEF_PIA_BASE      = 16'hD010;
    localparam logic [7:0]  DEF_OPEN_BUS      = 8'h00;

    // Address decode with fixed priority ROM > RAM > PIA > NONE.
    // rom_page is the ROM base page, ram_limit is 2^RAM_ADDR_BITS and
    // pia_blk is the PIA base with its two register-offset bits dropped.
    function automatic sel_t decode_addr(
        input logic [15:0] addr,
        input logic [7:0]  rom_page,
        input logic [16:0] ram_limit,
        input logic [13:0] pia_blk
    );
        sel_t sel;
        if (addr[15:8] == rom_page) begin
            sel = SEL_ROM;
        end else if ({1'b0, addr} < ram_limit) begin
            sel = SEL_RAM;
        end else if (addr[15:2] == pia_blk) begin
            sel = SEL_PIA;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pia_kbd_dsp.sv
// Apple-1 PIA register model: keyboard latch with strobe flag, display
// output handshake, the two control registers and the registered read mux.
module pia_kbd_dsp
    import apple1_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_clken,
    input  logic       cpu_we,
    input  logic       pia_sel,
    input  logic [1:0] reg_off,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] pia_rdata_q,
    input  logic [6:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    output logic [6:0] dsp_data,
    output logic       dsp_valid,
    input  logic       dsp_ready
);

    logic [6:0] kbd_char_r;
    logic       kbd_flag_r;
    logic [6:0] kbdcr_r;
    logic [7:0] dspcr_r;
    logic [6:0] dsp_data_r;
    logic       dsp_valid_r;
    logic [7:0] pia_rdata_r;
    logic [7:0] rd_mux_s;

    logic       wr_s;
    logic       rd_s;
    logic       kbd_accept_s;
    logic       kbd_clear_s;
    logic       dsp_load_s;
    logic       dsp_done_s;

    // CPU-side accesses only count on an enabled CPU cycle
    assign wr_s = cpu_clken & cpu_we & pia_sel;
    assign rd_s = cpu_clken & ~cpu_we & pia_sel;

    // A new key is only accepted while the flag is clear, so accept and
    // the read-clear below can never fire in the same clock.
    assign kbd_accept_s = kbd_valid & ~kbd_flag_r;
    assign kbd_clear_s  = rd_s & (reg_off == PIA_KBD) & kbd_flag_r;

    // Busy is sampled before the edge: a write landing in the handshake
    // clock sees dsp_valid_r=1 and is dropped.
    assign dsp_load_s = wr_s & (reg_off == PIA_DSP) & ~dsp_valid_r;
    assign dsp_done_s = dsp_valid_r & dsp_ready;

    // Register read mux, selected by the low address bits
    always_comb begin
        rd_mux_s = 8'h00;
        case (reg_off)
            PIA_KBD:   rd_mux_s = {1'b1, kbd_char_r};
            PIA_KBDCR: rd_mux_s = {kbd_flag_r, kbdcr_r};
            PIA_DSP:   rd_mux_s = {dsp_valid_r, 7'b000_0000};
            PIA_DSPCR: rd_mux_s = dspcr_r;
            default:   rd_mux_s = 8'h00;
        endcase
    end

    // Keyboard latch and strobe flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbd_char_r <= 7'h00;
            kbd_flag_r <= 1'b0;
        end else if (kbd_accept_s) begin
            kbd_char_r <= kbd_data;
            kbd_flag_r <= 1'b1;
        end else if (kbd_clear_s) begin
            kbd_flag_r <= 1'b0;
        end
    end

    // Display character register and pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_data_r  <= 7'h00;
            dsp_valid_r <= 1'b0;
        end else if (dsp_done_s) begin
            dsp_valid_r <= 1'b0;
        end else if (dsp_load_s) begin
            dsp_data_r  <= cpu_wdata[6:0];
            dsp_valid_r <= 1'b1;
        end
    end

    // Control registers; a write to KBD itself is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbdcr_r <= 7'h00;
            dspcr_r <= 8'h00;
        end else if (wr_s && (reg_off == PIA_KBDCR)) begin
            kbdcr_r <= cpu_wdata[6:0];
        end else if (wr_s && (reg_off == PIA_DSPCR)) begin
            dspcr_r <= cpu_wdata;
        end
    end

    // Read data captured every clock to line up with the ROM/RAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pia_rdata_r <= 8'h00;
        end else begin
            pia_rdata_r <= rd_mux_s;
        end
    end

    assign pia_rdata_q = pia_rdata_r;
    assign kbd_ready   = ~kbd_flag_r;
    assign dsp_data    = dsp_data_r;
    assign dsp_valid   = dsp_valid_r;

endmodule

// File: rtl/apple1_bus_decoder.sv
// Apple-1 bus decoder: decodes the 6502 address onto ROM, RAM and PIA,
// pipelines the selection by one clock to match the synchronous memory
// latency and muxes the read data back to the CPU.
module apple1_bus_decoder
    import apple1_bus_pkg::*;
#(
    parameter int          RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
    parameter logic [15:0] ROM_BASE      = DEF_ROM_BASE,
    parameter logic [15:0] PIA_BASE      = DEF_PIA_BASE,
    parameter logic [7:0]  OPEN_BUS      = DEF_OPEN_BUS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_clken,
    input  logic [15:0]              cpu_addr,
    input  logic                     cpu_we,
    input  logic [7:0]               cpu_wdata,
    output logic [7:0]               cpu_rdata,
    output logic [7:0]               rom_addr,
    input  logic [7:0]               rom_dout,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic                     ram_cs,
    output logic                     ram_we,
    input  logic [7:0]               ram_dout,
    input  logic [6:0]               kbd_data,
    input  logic                     kbd_valid,
    output logic                     kbd_ready,
    output logic [6:0]               dsp_data,
    output logic                     dsp_valid,
    input  logic                     dsp_ready
);

    localparam logic [16:0] RAM_LIMIT = 17'd1 << RAM_ADDR_BITS;

    sel_t       sel_s;
    sel_t       sel_q;
    logic [7:0] pia_rdata_s;

    assign sel_s = decode_addr(cpu_addr, ROM_BASE[15:8], RAM_LIMIT, PIA_BASE[15:2]);

    // ROM writes are simply not forwarded: the ROM has no write port
    assign rom_addr = cpu_addr[7:0];
    assign ram_addr = cpu_addr[RAM_ADDR_BITS-1:0];
    assign ram_cs   = (sel_s == SEL_RAM);
    assign ram_we   = ram_cs & cpu_we & cpu_clken;

    // Selection follows the address every clock so data lines up with
    // the memories even on cycles where the CPU is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= SEL_NONE;
        end else begin
            sel_q <= sel_s;
        end
    end

    // Read data mux steered by the previous clock's selection
    always_comb begin
        cpu_rdata = OPEN_BUS;
        case (sel_q)
            SEL_ROM:  cpu_rdata = rom_dout;
            SEL_RAM:  cpu_rdata = ram_dout;
            SEL_PIA:  cpu_rdata = pia_rdata_s;
            SEL_NONE: cpu_rdata = OPEN_BUS;
            default:  cpu_rdata = OPEN_BUS;
        endcase
    end

    pia_kbd_dsp u_pia (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_clken   (cpu_clken),
        .cpu_we      (cpu_we),
        .pia_sel     (sel_s == SEL_PIA),
        .reg_off     (cpu_addr[1:0]),
        .cpu_wdata   (cpu_wdata),
        .pia_rdata_q (pia_rdata_s),
        .kbd_data    (kbd_data),
        .kbd_valid   (kbd_valid),
        .kbd_ready   (kbd_ready),
        .dsp_data    (dsp_data),
        .dsp_valid   (dsp_valid),
        .dsp_ready   (dsp_ready)
    );

endmodule

// File: doc/apple1_bus_decoder.md
Name: apple1_bus_decoder

Overview:
- Sits between the 6502 core and the memory/IO slaves: Woz Mon ROM, RAM, and the keyboard/display PIA registers.
- Decodes the CPU address and drives chip selects and slave addresses.
- Registers the selection so the read mux lines up with the 1-cycle synchronous ROM/RAM read latency.
- Implements the Apple-1 PIA register model: keyboard latch with strobe, and display output handshake.

Parameters:
- RAM_ADDR_BITS, 12, RAM occupies $0000 to (2^RAM_ADDR_BITS)-1
- ROM_BASE, 16'hFF00, base of the 256-byte Woz Mon window ($FF00-$FFFF)
- PIA_BASE, 16'hD010, base of the 4 PIA registers (KBD, KBDCR, DSP, DSPCR)
- OPEN_BUS, 8'h00, read value for unmapped addresses

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_clken  in  1  CPU cycle enable; all CPU-side accesses and side effects are qualified by it
- cpu_addr  in  16  CPU address
- cpu_we  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data to CPU; valid one clk after the address
- rom_addr  out  8  cpu_addr[7:0] to the Woz Mon ROM
- rom_dout  in  8  ROM read data (1-clk latency)
- ram_addr  out  RAM_ADDR_BITS  cpu_addr low bits
- ram_cs  out  1  RAM select (combinational)
- ram_we  out  1  ram_cs & cpu_we & cpu_clken
- ram_dout  in  8  RAM read data (1-clk latency)
- kbd_data  in  7  ASCII from keyboard source
- kbd_valid  in  1  keyboard char offered
- kbd_ready  out  1  block can accept a char
- dsp_data  out  7  char to display
- dsp_valid  out  1  char pending for display
- dsp_ready  in  1  display accepts char

Behaviour:
- Decode (combinational) selects one of ROM, RAM, PIA or NONE.
  - ROM: cpu_addr[15:8]==ROM_BASE[15:8].
  - RAM: cpu_addr < 2^RAM_ADDR_BITS.
  - PIA: cpu_addr[15:2]==PIA_BASE[15:2].
  - NONE: anything else.
- sel_q and pia_rdata_q are registered every clk, independent of cpu_clken.
- cpu_rdata = mux(sel_q): rom_dout, ram_dout, pia_rdata_q, or OPEN_BUS.
- Read latency is exactly 1 clk: the address at edge N gives data on cpu_rdata after edge N+1.
- ROM writes are ignored, with no side effect.
- PIA register map, by offset:
  - 0 KBD read = {1'b1, kbd_char}.
  - 1 KBDCR read = {kbd_flag, kbdcr[6:0]}.
  - 2 DSP read = {dsp_valid, 7'b0}.
  - 3 DSPCR read = dspcr.
- Keyboard path:
  - kbd_ready = ~kbd_flag.
  - kbd_valid & kbd_ready: latch kbd_data, set kbd_flag.
  - A cpu_clken read of KBD clears kbd_flag.
  - Read and new-char accept in the same clk cannot occur, because kbd_ready is low whenever the flag is set.
  - A read of KBD with kbd_flag=0 returns the stale char and has no effect.
- Display path:
  - A cpu_clken write to DSP with dsp_valid=0 loads dsp_data=cpu_wdata[6:0] and sets dsp_valid.
  - A write while dsp_valid=1 is dropped.
  - dsp_valid & dsp_ready clears dsp_valid next clk.
  - A write in the same clk as the handshake completes is dropped, because busy is sampled pre-edge.
- Writes to KBDCR and DSPCR store cpu_wdata[6:0] and cpu_wdata[7:0] respectively. A write to KBD has no effect.
- Side effects (KBD read clear, all writes) occur only when cpu_clken=1. A held address without cpu_clken never clears kbd_flag.
- Reset values (asynchronous):
  - sel_q=NONE, cpu_rdata=OPEN_BUS.
  - kbd_char=0, kbd_flag=0 so kbd_ready=1.
  - dsp_data=0, dsp_valid=0.
  - kbdcr=0, dspcr=0, pia_rdata_q=0.
- Reset asserted mid-handshake discards the pending char and the latched key. No dsp_valid is reasserted after release.

Decomposition:
- Package apple1_bus_pkg holds:
  - sel_t enum {SEL_NONE, SEL_ROM, SEL_RAM, SEL_PIA};
  - PIA offset constants KBD/KBDCR/DSP/DSPCR;
  - default map constants.
- Sub-module pia_kbd_dsp holds the keyboard/display registers, handshakes and the PIA read mux. The top level handles decode, select pipelining and the data mux.

Test Plan:
- Read cpu_addr=$FFFC with rom_dout driven $00 then $FF: cpu_rdata=$00, then $FF one clk later. Read $0123 routes ram_dout. Read $C000 gives $00.
- kbd_valid with kbd_data=$41: kbd_ready drops, KBDCR read gives bit7=1. KBD read gives $C1 and clears the flag. Next KBDCR read gives bit7=0 and kbd_ready=1.
- KBD address held with cpu_clken=0 for 10 clks: kbd_flag stays 1.
- Write $8D to DSP: dsp_data=$0D, dsp_valid=1, DSP read gives $80. A second write of $41 while busy is dropped. dsp_ready=1 for 1 clk clears dsp_valid, and DSP reads $00.
- Write $A7 to DSPCR and $FF to KBDCR: read back $A7 and $7F (flag clear). Write $55 to $FF00: no effect, ram_we stays 0.
- rst_n pulsed low while dsp_valid=1 and kbd_flag=1: both clear asynchronously, cpu_rdata=$00, kbd_ready=1.
